// File: rtl/nbit_sqrt.sv
// nbit_sqrt -- sequential integer square root (digit-by-digit, restoring).
//
// Computes out = floor(sqrt(a)) and rem = a - out^2 for a 2N-bit radicand.
// One root bit is resolved per clock, MSB first. After start is accepted,
// the result appears after N clock edges.
//
// Ports
//   clk     in   1      rising-edge clock
//   rst     in   1      asynchronous active-low reset
//   start   in   1      request, accepted only when idle
//   a_in    in   2N     radicand, latched on the accepting edge
//   out     out  N      root, held until the next completion
//   rem     out  N+1    remainder a - out^2, valid with out
//   busy    out  1      high while a computation is in flight
//   finish  out  1      one-cycle pulse when out/rem have just been updated
module nbit_sqrt #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] a_in,
  output logic [N-1:0]   out,
  output logic [N:0]     rem,
  output logic           busy,
  output logic           finish
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, CALC} state_t;

  state_t         state_q,  state_d;
  logic [2*N-1:0] shift_q,  shift_d;
  logic [N-1:0]   root_q,   root_d;
  // Before the final step the partial root has at most N-1 bits and the
  // working remainder is bounded by 2*root, so N bits hold it. Only the
  // final step can produce an N+1-bit remainder, and that value goes
  // straight to rem.
  logic [N-1:0]   r_q,      r_d;
  logic [CW-1:0]  cnt_q,    cnt_d;
  logic [N-1:0]   out_q,    out_d;
  logic [N:0]     rem_q,    rem_d;
  logic           busy_q,   busy_d;
  logic           finish_q, finish_d;

  // One restoring iteration.
  logic [N+1:0] r_shift;
  logic [N+1:0] trial;
  logic         ge;
  logic [N:0]   r_sub;
  logic [N:0]   r_next;
  logic [N-1:0] root_next;

  always_comb begin
    r_shift   = {r_q, shift_q[2*N-1 -: 2]};
    trial     = {root_q, 2'b01};
    ge        = (r_shift >= trial);
    // The true difference is <= 2*root_next, which fits in N+1 bits, so
    // the subtraction can be done modulo 2^(N+1).
    r_sub     = r_shift[N:0] - trial[N:0];
    r_next    = ge ? r_sub : r_shift[N:0];
    root_next = {root_q[N-2:0], ge};
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    root_d   = root_q;
    r_d      = r_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    rem_d    = rem_q;
    busy_d   = busy_q;
    finish_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = a_in;
          root_d  = '0;
          r_d     = '0;
          cnt_d   = CW'(N - 1);
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        shift_d = shift_q << 2;
        root_d  = root_next;
        r_d     = r_next[N-1:0];
        if (cnt_q == '0) begin
          out_d    = root_next;
          rem_d    = r_next;
          finish_d = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      root_q   <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      rem_q    <= '0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      root_q   <= root_d;
      r_q      <= r_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      rem_q    <= rem_d;
      busy_q   <= busy_d;
      finish_q <= finish_d;
    end
  end

  assign out    = out_q;
  assign rem    = rem_q;
  assign busy   = busy_q;
  assign finish = finish_q;

endmodule

// File: tb/tb_nbit_sqrt.sv
// tb_nbit_sqrt -- self-checking bench for nbit_sqrt (N=8 and N=4 instances).
module tb_nbit_sqrt;

  typedef struct {
    int a;
    int root;
    int rem;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        start  = 1'b0;
  logic [15:0] a_in   = '0;
  logic [7:0]  out;
  logic [8:0]  rem;
  logic        busy;
  logic        finish;

  logic        start4 = 1'b0;
  logic [7:0]  a4     = '0;
  logic [3:0]  out4;
  logic [4:0]  rem4;
  logic        busy4;
  logic        finish4;

  int n_asserts = 0;
  int n_fail    = 0;

  exp_t q8[$];
  exp_t q4[$];

  always #5 clk = ~clk;

  nbit_sqrt #(.N(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in),
    .out(out), .rem(rem), .busy(busy), .finish(finish)
  );

  nbit_sqrt #(.N(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a_in(a4),
    .out(out4), .rem(rem4), .busy(busy4), .finish(finish4)
  );

  function automatic int isqrt(int a);
    int r = 0;
    while ((r + 1) * (r + 1) <= a) r++;
    return r;
  endfunction

  function automatic exp_t mk_exp(int a);
    exp_t e;
    e.a    = a;
    e.root = isqrt(a);
    e.rem  = a - e.root * e.root;
    return e;
  endfunction

  // Scoreboard monitors: pop the expected result on each finish pulse.
  always @(negedge clk) begin
    if (rst && finish) begin
      n_asserts++;
      assert (q8.size() != 0) else begin
        n_fail++; $error("FAIL n8_extra_finish out=%0d rem=%0d required no finish", out, rem);
      end
      if (q8.size() != 0) begin
        exp_t e;
        e = q8.pop_front();
        n_asserts++;
        assert (32'(out) === e.root) else begin
          n_fail++; $error("FAIL n8_root a=%0d got=%0d exp=%0d", e.a, out, e.root);
        end
        n_asserts++;
        assert (32'(rem) === e.rem) else begin
          n_fail++; $error("FAIL n8_rem a=%0d got=%0d exp=%0d", e.a, rem, e.rem);
        end
        n_asserts++;
        assert ((32'(out) * 32'(out) + 32'(rem) == 32'(e.a)) && (32'(rem) <= 2 * 32'(out))) else begin
          n_fail++; $error("FAIL n8_invariant a=%0d got out=%0d rem=%0d exp out*out+rem==a", e.a, out, rem);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst && finish4) begin
      n_asserts++;
      assert (q4.size() != 0) else begin
        n_fail++; $error("FAIL n4_extra_finish out=%0d rem=%0d required no finish", out4, rem4);
      end
      if (q4.size() != 0) begin
        exp_t e;
        e = q4.pop_front();
        n_asserts++;
        assert (32'(out4) === e.root && 32'(rem4) === e.rem) else begin
          n_fail++; $error("FAIL n4_result a=%0d got=%0d/%0d exp=%0d/%0d", e.a, out4, rem4, e.root, e.rem);
        end
        n_asserts++;
        assert ((32'(out4) * 32'(out4) + 32'(rem4) == 32'(e.a)) && (32'(rem4) <= 2 * 32'(out4))) else begin
          n_fail++; $error("FAIL n4_invariant a=%0d got out=%0d rem=%0d exp out*out+rem==a", e.a, out4, rem4);
        end
      end
    end
  end

  // Single operation with latency and busy-width checks.
  task automatic run_op(input int a);
    int cyc;
    int bcnt;
    @(negedge clk);
    a_in  = 16'(a);
    start = 1'b1;
    q8.push_back(mk_exp(a));
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in  = 16'($urandom);
    cyc  = 0;
    bcnt = 0;
    while (!finish && cyc < 50) begin
      if (busy) bcnt++;
      @(posedge clk);
      #1;
      cyc++;
    end
    n_asserts++;
    assert (cyc === 8) else begin
      n_fail++; $error("FAIL latency a=%0d got=%0d exp=8", a, cyc);
    end
    n_asserts++;
    assert (bcnt === 8) else begin
      n_fail++; $error("FAIL busy_width a=%0d got=%0d exp=8", a, bcnt);
    end
    $display("op a=%0d out=%0d rem=%0d latency=%0d", a, out, rem, cyc);
  endtask

  task automatic wait_finish(input string tag);
    int cyc = 0;
    while (!finish && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    n_asserts++;
    assert (finish === 1'b1) else begin
      n_fail++; $error("FAIL %s_timeout got finish=%b exp=1", tag, finish);
    end
  endtask

  // start held high: one accepted op every 9 cycles, a_in scrambled while busy.
  task automatic b2b8(input int num);
    int v;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < num; i++) begin
      v    = int'($urandom_range(0, 65535));
      if (i == 0) v = 65535;
      a_in = 16'(v);
      q8.push_back(mk_exp(v));
      @(posedge clk);
      #1;
      a_in = 16'($urandom);
      repeat (8) @(posedge clk);
      #1;
      n_asserts++;
      assert (finish === 1'b1) else begin
        n_fail++; $error("FAIL b2b8_period a=%0d got finish=%b exp=1", v, finish);
      end
      if (i < 5) $display("b2b8 a=%0d out=%0d rem=%0d", v, out, rem);
      if (i == num - 1) start = 1'b0;
    end
  endtask

  task automatic b2b4_exhaustive();
    @(negedge clk);
    start4 = 1'b1;
    for (int v = 0; v < 256; v++) begin
      a4 = 8'(v);
      q4.push_back(mk_exp(v));
      @(posedge clk);
      #1;
      a4 = 8'($urandom);
      repeat (4) @(posedge clk);
      #1;
      n_asserts++;
      assert (finish4 === 1'b1) else begin
        n_fail++; $error("FAIL b2b4_period a=%0d got finish=%b exp=1", v, finish4);
      end
      if (v == 255) start4 = 1'b0;
    end
    $display("n4 exhaustive sweep done, last out=%0d rem=%0d", out4, rem4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    n_asserts++;
    assert (out === 8'd0 && rem === 9'd0) else begin
      n_fail++; $error("FAIL reset_outputs got=%0d/%0d exp=0/0", out, rem);
    end
    n_asserts++;
    assert (busy === 1'b0 && finish === 1'b0) else begin
      n_fail++; $error("FAIL reset_flags got busy=%b finish=%b exp 0/0", busy, finish);
    end
    @(negedge clk);
    rst = 1'b1;

    // Directed operands
    run_op(0);
    run_op(144);
    run_op(200);
    run_op(65535);

    // start and a_in changes during CALC are ignored
    @(negedge clk);
    a_in  = 16'd200;
    start = 1'b1;
    q8.push_back(mk_exp(200));
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    a_in  = 16'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_finish("ignore_start");
    repeat (12) @(posedge clk);
    #1;
    n_asserts++;
    assert (q8.size() === 0 && busy === 1'b0) else begin
      n_fail++; $error("FAIL ignore_start pending=%0d busy=%b exp 0/0", q8.size(), busy);
    end
    $display("ignore mid-CALC start: out=%0d rem=%0d", out, rem);

    // Asynchronous reset mid-CALC
    @(negedge clk);
    a_in  = 16'd1000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_asserts++;
    assert (out === 8'd0 && rem === 9'd0) else begin
      n_fail++; $error("FAIL async_rst_outputs got=%0d/%0d exp=0/0", out, rem);
    end
    n_asserts++;
    assert (busy === 1'b0 && finish === 1'b0) else begin
      n_fail++; $error("FAIL async_rst_flags got busy=%b finish=%b exp 0/0", busy, finish);
    end
    @(negedge clk);
    rst = 1'b1;
    run_op(50000);

    // Back-to-back: directed full-scale first, then random
    b2b8(1000);

    // N=4 exhaustive
    b2b4_exhaustive();

    repeat (3) @(negedge clk);
    n_asserts++;
    assert (q8.size() === 0 && q4.size() === 0) else begin
      n_fail++; $error("FAIL scoreboard_drain got=%0d/%0d exp=0/0", q8.size(), q4.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
